// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_deframer: UART receive front end, mid-bit sampling, raw parity out.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       rx_serial_in,
  output logic [7:0] SIPO_data_out,
  output logic       parity_bit_out,
  output logic       paritybit_check_enable_out,
  output logic       frame_valid_out,
  output logic       framing_error_out,
  output logic       rx_busy_out
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        sync1, sync2;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        par_reg;
  logic        strobe_second;

  logic rx_s;
  logic cnt_run, cnt_clr, idx_clr, idx_inc, shift_en, par_en, good_frame, bad_frame;
  logic bit_done, half_done;

  assign rx_s        = sync2;
  assign bit_done    = (clk_cnt == BIT_LAST);
  assign half_done   = (clk_cnt == HALF_LAST);
  assign rx_busy_out = (state != IDLE);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_run    = 1'b0;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_nxt = START;
      end
      START: begin
        cnt_run = 1'b1;
        if (half_done) begin
          idx_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_run = 1'b1;
        if (bit_done) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          else                 idx_inc   = 1'b1;
        end
      end
      PARITY: begin
        cnt_run = 1'b1;
        if (bit_done) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        cnt_run = 1'b1;
        if (bit_done) begin
          if (rx_s) begin
            good_frame = 1'b1;
            state_nxt  = IDLE;
          end else begin
            bad_frame = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync1                      <= 1'b1;
      sync2                      <= 1'b1;
      clk_cnt                    <= 16'd0;
      bit_idx                    <= 3'd0;
      shift_reg                  <= 8'd0;
      par_reg                    <= 1'b0;
      SIPO_data_out              <= 8'd0;
      parity_bit_out             <= 1'b0;
      frame_valid_out            <= 1'b0;
      framing_error_out          <= 1'b0;
      paritybit_check_enable_out <= 1'b0;
      strobe_second              <= 1'b0;
    end else begin
      sync1 <= rx_serial_in;
      sync2 <= sync1;

      if (!cnt_run || cnt_clr || (state_nxt != state)) clk_cnt <= 16'd0;
      else                                             clk_cnt <= clk_cnt + 16'd1;

      if (idx_clr)      bit_idx <= 3'd0;
      else if (idx_inc) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
      if (par_en)   par_reg   <= rx_s;

      frame_valid_out   <= good_frame;
      framing_error_out <= bad_frame;

      // Strobe is two cycles long; the second cycle comes from strobe_second.
      if (good_frame) begin
        SIPO_data_out              <= shift_reg;
        parity_bit_out             <= par_reg;
        paritybit_check_enable_out <= 1'b1;
        strobe_second              <= 1'b1;
      end else begin
        paritybit_check_enable_out <= strobe_second;
        strobe_second              <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// Testbench for uart_rx_deframer: directed scenarios plus randomized frames
// checked against a frame-level queue model.
module tb_uart_rx_deframer;

  localparam int BIT = 16;
  localparam int PE  = 1;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] SIPO_data_out;
  logic       parity_bit_out, en, fv, fe, busy;

  uart_rx_deframer #(.CLKS_PER_BIT(BIT), .PARITY_EN(PE)) dut (
    .Clk                        (Clk),
    .reset                      (reset),
    .rx_serial_in               (rx),
    .SIPO_data_out              (SIPO_data_out),
    .parity_bit_out             (parity_bit_out),
    .paritybit_check_enable_out (en),
    .frame_valid_out            (fv),
    .framing_error_out          (fe),
    .rx_busy_out                (busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Observed activity, recorded away from the active edge.
  logic [8:0] obs_q[$];
  int         runs_q[$];
  int         fe_cnt = 0;
  int         stable_viol = 0;
  int         run = 0;
  bit         busy_seen = 0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_en = 1'b0;
  logic [7:0] last_good = 8'd0;

  always @(negedge Clk) begin
    if (fv) obs_q.push_back({parity_bit_out, SIPO_data_out});
    if (fe) fe_cnt++;
    if (busy) busy_seen = 1;
    if (en) run++;
    else if (run > 0) begin
      runs_q.push_back(run);
      run = 0;
    end
    if (en && prev_en && (SIPO_data_out != prev_data)) stable_viol++;
    prev_en   = en;
    prev_data = SIPO_data_out;
  end

  task automatic clear_stats();
    obs_q.delete();
    runs_q.delete();
    fe_cnt    = 0;
    busy_seen = 0;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(negedge Clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PE != 0) drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (SIPO_data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", SIPO_data_out); end
    checks++; if (parity_bit_out !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", parity_bit_out); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", en); end
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fv); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", fe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    idle_bits(2);
    clear_stats();
  endtask

  task automatic test_good_frame(input string name, input logic [7:0] d, input logic p);
    clear_stats();
    send_frame(d, p, 1'b1);
    idle_bits(2);
    last_good = d;
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL %s_count got %0d want 1", name, obs_q.size()); end
    checks++; if (SIPO_data_out !== d) begin errors++; $display("FAIL %s_data got %h want %h", name, SIPO_data_out, d); end
    checks++; if (parity_bit_out !== p) begin errors++; $display("FAIL %s_parity got %b want %b", name, parity_bit_out, p); end
    checks++; if (runs_q.size() != 1 || runs_q[0] != 2) begin errors++; $display("FAIL %s_strobe runs %0d first %0d want one run of 2", name, runs_q.size(), (runs_q.size() > 0) ? runs_q[0] : -1); end
    checks++; if (fe_cnt != 0) begin errors++; $display("FAIL %s_ferr got %0d want 0", name, fe_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", name, busy); end
  endtask

  task automatic test_glitch();
    int wait_cyc;
    clear_stats();
    rx = 1'b0;
    repeat (5) @(negedge Clk);
    rx = 1'b1;
    wait_cyc = 0;
    while (busy === 1'b1 && wait_cyc < 16) begin
      @(negedge Clk);
      wait_cyc++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_release got %b want 0 after %0d cycles", busy, wait_cyc); end
    idle_bits(2);
    checks++; if (!busy_seen) begin errors++; $display("FAIL glitch_busy_seen got 0 want 1"); end
    checks++; if (obs_q.size() != 0 || fe_cnt != 0 || runs_q.size() != 0) begin errors++; $display("FAIL glitch_pulses got valid %0d ferr %0d strobes %0d want 0", obs_q.size(), fe_cnt, runs_q.size()); end
  endtask

  task automatic test_framing();
    int drops;
    int wait_cyc;
    clear_stats();
    send_frame(8'h3C, 1'b0, 1'b0);
    drops = 0;
    rx = 1'b0;
    repeat (40 * BIT) begin
      @(negedge Clk);
      if (busy !== 1'b1) drops++;
    end
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL framing_pulses got %0d want 1", fe_cnt); end
    checks++; if (SIPO_data_out !== last_good) begin errors++; $display("FAIL framing_data got %h want %h", SIPO_data_out, last_good); end
    checks++; if (obs_q.size() != 0 || runs_q.size() != 0) begin errors++; $display("FAIL framing_valid got valid %0d strobes %0d want 0", obs_q.size(), runs_q.size()); end
    checks++; if (drops != 0) begin errors++; $display("FAIL framing_wait_idle got %0d non-busy cycles want 0", drops); end
    rx = 1'b1;
    wait_cyc = 0;
    while (busy === 1'b1 && wait_cyc < 8) begin
      @(negedge Clk);
      wait_cyc++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL framing_release got %b want 0", busy); end
    idle_bits(2);
  endtask

  task automatic test_back_to_back();
    clear_stats();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(2);
    last_good = 8'hFF;
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", obs_q.size()); end
    checks++; if (obs_q.size() > 0 && obs_q[0] !== 9'h055) begin errors++; $display("FAIL b2b_first got %h want 055", obs_q[0]); end
    checks++; if (obs_q.size() > 1 && obs_q[1] !== 9'h0FF) begin errors++; $display("FAIL b2b_second got %h want 0ff", obs_q[1]); end
    checks++; if (runs_q.size() != 2) begin errors++; $display("FAIL b2b_strobe_count got %0d want 2", runs_q.size()); end
    foreach (runs_q[i]) begin
      checks++; if (runs_q[i] != 2) begin errors++; $display("FAIL b2b_strobe_len[%0d] got %0d want 2", i, runs_q[i]); end
    end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL b2b_stable got %0d changes want 0", stable_viol); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    repeat (BIT / 2) @(negedge Clk);
    reset = 1'b1;
    #1;
    checks++; if (SIPO_data_out !== 8'h00 || parity_bit_out !== 1'b0) begin errors++; $display("FAIL rstmid_data got %h/%b want 00/0", SIPO_data_out, parity_bit_out); end
    checks++; if (busy !== 1'b0 || en !== 1'b0 || fv !== 1'b0 || fe !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy %b en %b fv %b fe %b want 0", busy, en, fv, fe); end
    rx = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    idle_bits(2);
    checks++; if (obs_q.size() != 0 || fe_cnt != 0) begin errors++; $display("FAIL rstmid_pulses got valid %0d ferr %0d want 0", obs_q.size(), fe_cnt); end
    last_good = 8'h00;
    test_good_frame("after_reset", 8'h81, 1'b0);
  endtask

  task automatic test_random(input int n);
    logic [8:0] exp_q[$];
    int         exp_fe;
    logic [7:0] d;
    logic       p, stop;
    clear_stats();
    stable_viol = 0;
    exp_fe = 0;
    for (int k = 0; k < n; k++) begin
      d    = 8'($urandom);
      p    = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, p, stop);
      if (stop) begin
        exp_q.push_back({p, d});
        last_good = d;
        idle_bits($urandom_range(0, 2));
      end else begin
        exp_fe++;
        rx = 1'b0;
        repeat ($urandom_range(0, 3) * BIT) @(negedge Clk);
        idle_bits(1 + $urandom_range(0, 1));
      end
    end
    idle_bits(3);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (runs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_strobes got %0d want %0d", runs_q.size(), exp_q.size()); end
    foreach (runs_q[i]) begin
      checks++; if (runs_q[i] != 2) begin errors++; $display("FAIL rand_strobe_len[%0d] got %0d want 2", i, runs_q[i]); end
    end
    checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL rand_ferr got %0d want %0d", fe_cnt, exp_fe); end
    checks++; if (SIPO_data_out !== last_good) begin errors++; $display("FAIL rand_last_data got %h want %h", SIPO_data_out, last_good); end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL rand_stable got %0d changes want 0", stable_viol); end
  endtask

  initial begin
    test_reset();
    test_good_frame("a5", 8'hA5, 1'b0);
    checks++; if (parity_bit_out !== ^8'hA5) begin errors++; $display("FAIL a5_even_parity got %b want %b", parity_bit_out, ^8'hA5); end
    test_good_frame("corrupt01", 8'h01, 1'b0);
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_random(24);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
